// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and types for the 8-way round-robin arbiter.
//   N_REQ        number of requesters
//   ID_W         width of an encoded requester index
//   arb_state_e  arbiter FSM state encoding
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/pri_enc8.sv
// -----------------------------------------------------------------------------
// pri_enc8
// Combinational 8->3 priority encoder; the highest set index wins.
// Ports:
//   in     [7:0]  input vector
//   id     [2:0]  index of the highest set bit (0 when in == 0)
//   valid         at least one bit of in is set
// -----------------------------------------------------------------------------
module pri_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  // Highest-index-first encode of the input vector.
  always_comb begin
    id    = 3'd0;
    valid = |in;
    casez (in)
      8'b1???_????: id = 3'd7;
      8'b01??_????: id = 3'd6;
      8'b001?_????: id = 3'd5;
      8'b0001_????: id = 3'd4;
      8'b0000_1???: id = 3'd3;
      8'b0000_01??: id = 3'd2;
      8'b0000_001?: id = 3'd1;
      8'b0000_0001: id = 3'd0;
      default:      id = 3'd0;
    endcase
  end

endmodule : pri_enc8

// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
// Round-robin arbiter for 8 requesters with a grant-until-done handshake.
// Within the window below the previous winner the highest index wins; when
// nothing is requesting inside that window, the highest index overall wins.
// A grant is held until done, withdrawal of the owner's request, or the
// optional hold timeout; a one-cycle idle turnaround follows every release.
// Parameters:
//   TIMEOUT  max cycles a grant is held without done (0 disables)
// Ports:
//   clk      rising-edge clock
//   reset    synchronous reset, active-high
//   req      [7:0] level-sensitive request vector
//   done     owner releases the resource (only looked at while granted)
//   gnt      [7:0] one-hot grant (registered)
//   gnt_id   [2:0] encoded granted index (registered)
//   gnt_vld  gnt/gnt_id valid (registered)
//   timeout  one-cycle pulse after a forced release (registered)
// -----------------------------------------------------------------------------
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  // Counter just wide enough to reach TIMEOUT; it restarts on every grant.
  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int HOLD_MAX_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] HOLD_MAX = HOLD_MAX_I[CNT_W-1:0];

  arb_state_e       state_r;
  logic [ID_W-1:0]  last_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [N_REQ-1:0] gnt_r;
  logic [ID_W-1:0]  gnt_id_r;
  logic             gnt_vld_r;
  logic             timeout_r;

  logic [N_REQ-1:0] mask_s;
  logic [N_REQ-1:0] masked_s;
  logic [ID_W-1:0]  masked_id_s;
  logic             masked_vld_s;
  logic [ID_W-1:0]  full_id_s;
  logic             full_vld_s;
  logic [ID_W-1:0]  win_id_s;
  logic             release_s;
  logic             force_rel_s;

  // Window of requesters strictly below the previous winner; last=0 gives an
  // empty window so the plain encoder (req7 first) decides.
  always_comb begin
    mask_s   = (8'h01 << last_r) - 8'h01;
    masked_s = req & mask_s;
  end

  pri_enc8 u_enc_masked (
    .in    (masked_s),
    .id    (masked_id_s),
    .valid (masked_vld_s)
  );

  pri_enc8 u_enc_full (
    .in    (req),
    .id    (full_id_s),
    .valid (full_vld_s)
  );

  // Prefer the rotating window; fall back to the whole request vector.
  always_comb begin
    if (masked_vld_s) begin
      win_id_s = masked_id_s;
    end else begin
      win_id_s = full_id_s;
    end
  end

  // Release decision while granted: done or withdrawal beat the timeout, so
  // the timeout pulse only fires when neither is present.
  always_comb begin
    release_s   = 1'b0;
    force_rel_s = 1'b0;
    if (done || !req[gnt_id_r]) begin
      release_s = 1'b1;
    end else if ((TIMEOUT != 0) && (hold_cnt_r == HOLD_MAX)) begin
      release_s   = 1'b1;
      force_rel_s = 1'b1;
    end else begin
      release_s   = 1'b0;
      force_rel_s = 1'b0;
    end
  end

  // Arbiter FSM with its pointer, hold counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= 3'd0;
      hold_cnt_r <= '0;
      gnt_r      <= 8'h00;
      gnt_id_r   <= 3'd0;
      gnt_vld_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (full_vld_s) begin
            state_r    <= ST_GRANT;
            gnt_vld_r  <= 1'b1;
            gnt_id_r   <= win_id_s;
            gnt_r      <= 8'h01 << win_id_s;
            last_r     <= win_id_s;
            hold_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          hold_cnt_r <= hold_cnt_r + CNT_W'(1);
          if (release_s) begin
            state_r   <= ST_IDLE;
            gnt_r     <= 8'h00;
            gnt_vld_r <= 1'b0;
            timeout_r <= force_rel_s;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gnt_r     <= 8'h00;
          gnt_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign gnt_vld = gnt_vld_r;
  assign timeout = timeout_r;

endmodule : rr_arbiter8

// File: tb/tb_rr_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter8
// Directed bench for rr_arbiter8 (TIMEOUT=4). Each step drives one cycle of
// inputs, queues the outputs expected after the next rising edge, then pops
// and checks them once the edge has passed.
// -----------------------------------------------------------------------------
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    string      tag;
    logic       vld;
    logic [2:0] id;
    logic       tmo;
    logic       chk_id;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs, queue expectation, check after the edge.
  task automatic step(input string tag, input logic r, input logic [7:0] rq,
                      input logic d, input logic e_vld, input logic [2:0] e_id,
                      input logic e_tmo, input logic e_chk_id);
    exp_t       e;
    logic [7:0] e_gnt;
    reset = r;
    req   = rq;
    done  = d;
    e.tag = tag; e.vld = e_vld; e.id = e_id; e.tmo = e_tmo; e.chk_id = e_chk_id;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tests_run++;
    assert (sb.size() == 1) else begin
      fails++;
      $error("FAIL %s scoreboard: observed depth %0d expected 1", tag, sb.size());
    end
    e = sb.pop_front();
    e_gnt = 8'h01;
    e_gnt = e.vld ? (e_gnt << e.id) : 8'h00;
    tests_run++;
    assert (gnt_vld === e.vld) else begin
      fails++;
      $error("FAIL %s gnt_vld: observed %b expected %b", e.tag, gnt_vld, e.vld);
    end
    tests_run++;
    assert (gnt === e_gnt) else begin
      fails++;
      $error("FAIL %s gnt: observed %h expected %h", e.tag, gnt, e_gnt);
    end
    tests_run++;
    assert (timeout === e.tmo) else begin
      fails++;
      $error("FAIL %s timeout: observed %b expected %b", e.tag, timeout, e.tmo);
    end
    if (e.chk_id) begin
      tests_run++;
      assert (gnt_id === e.id) else begin
        fails++;
        $error("FAIL %s gnt_id: observed %0d expected %0d", e.tag, gnt_id, e.id);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    done  = 1'b0;

    // 1. Reset dominates a full request vector; req7 wins first afterwards.
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step("first_grant", 1'b0, 8'hFF, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);

    // 2. All requesting, done in first grant cycle: 6..0 then wrap to 7.
    for (int k = 0; k < 8; k++) begin
      step("rot_release", 1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      step("rot_grant",   1'b0, 8'hFF, 1'b0, 1'b1, 3'(6 - k), 1'b0, 1'b1);
    end
    step("rot_end", 1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // 3. Two requesters alternate; mask falls back to full vector when empty.
    step("alt_5a", 1'b0, 8'h24, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    step("alt_r1", 1'b0, 8'h24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("alt_2a", 1'b0, 8'h24, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    step("alt_r2", 1'b0, 8'h24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("alt_5b", 1'b0, 8'h24, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
    step("alt_r3", 1'b0, 8'h24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    step("alt_2b", 1'b0, 8'h24, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    step("alt_r4", 1'b0, 8'h24, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // 4. Hold timeout: 4 grant cycles, 1-cycle pulse, regrant; then done wins.
    step("tmo_g0", 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("tmo_hold", 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    step("tmo_fire",  1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    step("tmo_regnt", 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("tmo_hold2", 1'b0, 8'h01, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    step("tmo_done_wins", 1'b0, 8'h01, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // 5. Others ignored while granted; withdrawal releases; rotate from 3.
    step("wd_grant3",  1'b0, 8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    step("wd_ignore",  1'b0, 8'hF8, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1);
    step("wd_drop",    1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    step("wd_next7",   1'b0, 8'h88, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1);
    step("wd_release", 1'b0, 8'h88, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // 6. Reset mid-grant clears outputs and the rotation pointer.
    step("mid_grant2", 1'b0, 8'h04, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
    step("mid_reset",  1'b1, 8'h04, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    step("post_reset", 1'b0, 8'h06, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rr_arbiter8
